// File: rtl/decoder_idx_seq.sv
// -----------------------------------------------------------------------------
// decoder_idx_seq
//
// Indexed-addressing sequencer. On an accepted start it captures the access
// mode and the selected index register, fetches a signed displacement, forms
// the effective address ea = base + sign_extend(disp) (mod 2^ADDR_W), then runs
// an optional read cycle and/or write cycle on the memory handshake before
// pulsing done.
//
// Ports
//   clk, reset            sole clock; synchronous active-high reset
//   start, mode, idx_sel  access request (sampled only while idle)
//   idx_regs              NUM_IDX packed index registers, reg i at [i*ADDR_W +: ADDR_W]
//   disp_valid/disp_data  displacement offer; disp_ready is the accept
//   mem_req/mem_we/mem_addr/mem_ack  memory cycle handshake
//   busy                  sequence in progress
//   done                  one-cycle completion pulse
//   err                   one-cycle pulse for an out-of-range idx_sel
// -----------------------------------------------------------------------------
module decoder_idx_seq #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DISP_W  = 8,
   parameter int unsigned NUM_IDX = 2,
   localparam int unsigned SEL_W  = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [SEL_W-1:0]           idx_sel,
   input  logic [NUM_IDX*ADDR_W-1:0]  idx_regs,
   input  logic                       disp_valid,
   input  logic [DISP_W-1:0]          disp_data,
   output logic                       disp_ready,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic                       mem_ack,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CALC,
      READ,
      WRITE,
      DONE
   } state_e;

   localparam logic [1:0] MODE_ADDR  = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;
   localparam logic [1:0] MODE_RMW   = 2'b11;

   // One extra bit so the range check stays meaningful when NUM_IDX is a
   // power of two (every encodable select is then valid).
   localparam logic [SEL_W:0] NUM_IDX_W = (SEL_W + 1)'(NUM_IDX);

   state_e              state_q, state_d;
   logic [1:0]          mode_q,  mode_d;
   logic [ADDR_W-1:0]   base_q,  base_d;
   logic [DISP_W-1:0]   disp_q,  disp_d;
   logic [ADDR_W-1:0]   ea_q,    ea_d;
   logic                err_q,   err_d;

   logic                sel_ok;
   logic [ADDR_W-1:0]   base_sel;
   logic [ADDR_W-1:0]   disp_ext;

   // --------------------------------------------------------------------------
   // Index register select and displacement sign extension
   // --------------------------------------------------------------------------
   always_comb begin
      sel_ok   = ({1'b0, idx_sel} < NUM_IDX_W);
      base_sel = '0;
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
         if (idx_sel == SEL_W'(i)) begin
            base_sel = idx_regs[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      disp_ext = ADDR_W'($signed(disp_q));
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start && sel_ok) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (disp_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            unique case (mode_q)
               MODE_ADDR:  state_d = DONE;
               MODE_WRITE: state_d = WRITE;
               MODE_READ,
               MODE_RMW:   state_d = READ;
               default:    state_d = DONE;
            endcase
         end
         READ: begin
            if (mem_ack) begin
               state_d = (mode_q == MODE_RMW) ? WRITE : DONE;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath registers: captured mode/base/displacement, effective address
   // and the error pulse.
   // --------------------------------------------------------------------------
   always_comb begin
      mode_d = mode_q;
      base_d = base_q;
      disp_d = disp_q;
      ea_d   = ea_q;
      err_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (sel_ok) begin
                  mode_d = mode;
                  base_d = base_sel;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (disp_valid) begin
               disp_d = disp_data;
            end
         end
         CALC: begin
            ea_d = base_q + disp_ext;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= '0;
         base_q <= '0;
         disp_q <= '0;
         ea_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         base_q <= base_d;
         disp_q <= disp_d;
         ea_q   <= ea_d;
         err_q  <= err_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs (decoded from registered state only)
   // --------------------------------------------------------------------------
   always_comb begin
      disp_ready = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      unique case (state_q)
         FETCH: disp_ready = 1'b1;
         READ:  mem_req    = 1'b1;
         WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         DONE:  done       = 1'b1;
         default: begin
         end
      endcase
      // ea_q only changes on the CALC exit edge, so the address is held
      // through IDLE until the next sequence recomputes it.
      mem_addr = ea_q;
      err      = err_q;
   end

endmodule

// File: tb/tb_decoder_idx_seq.sv
module tb_decoder_idx_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic        idx_sel;
   logic [31:0] idx_regs;
   logic        disp_valid;
   logic [7:0]  disp_data;
   logic        disp_ready;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        err;

   // Second instance with three index registers so an out-of-range select
   // can actually be encoded.
   logic        start3;
   logic [1:0]  sel3;
   logic [47:0] regs3;
   logic        disp_ready3;
   logic        mem_req3;
   logic        mem_we3;
   logic [15:0] mem_addr3;
   logic        busy3;
   logic        done3;
   logic        err3;

   int total;
   int bad;

   decoder_idx_seq u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .idx_sel    (idx_sel),
      .idx_regs   (idx_regs),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_ready (disp_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   decoder_idx_seq #(.NUM_IDX(3)) u_dut3 (
      .clk        (clk),
      .reset      (reset),
      .start      (start3),
      .mode       (mode),
      .idx_sel    (sel3),
      .idx_regs   (regs3),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_ready (disp_ready3),
      .mem_req    (mem_req3),
      .mem_we     (mem_we3),
      .mem_addr   (mem_addr3),
      .mem_ack    (mem_ack),
      .busy       (busy3),
      .done       (done3),
      .err        (err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: base plus signed 8-bit displacement, wrapped to 16 bits.
   function automatic logic [15:0] model_ea(input logic [15:0] b, input logic [7:0] d);
      int sd;
      int s;
      sd = (d >= 8'd128) ? int'(d) - 256 : int'(d);
      s  = int'(b) + sd;
      return s[15:0];
   endfunction

   // One memory cycle: request held for aw+1 cycles, ack on the last one.
   task automatic mem_phase(input logic we, input logic [15:0] a, input int aw);
      for (int c = 0; c <= aw; c++) begin
         chk("phase_req", mem_req, 1);
         chk("phase_we", mem_we, we);
         chk("phase_addr", mem_addr, a);
         chk("phase_done", done, 0);
         mem_ack = (c == aw);
         tick();
      end
      mem_ack = 1'b0;
   endtask

   task automatic run_txn(input logic sel, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [7:0] disp, input logic [1:0] md,
                          input int fw, input int aw);
      logic [15:0] exp_ea;
      exp_ea = model_ea(sel ? r1 : r0, disp);

      // Stray displacement and ack while idle must be ignored.
      start = 1'b0; disp_valid = 1'b1; disp_data = 8'($urandom); mem_ack = 1'b1;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_ready", disp_ready, 0);

      idx_regs = {r1, r0}; idx_sel = sel; mode = md;
      start = 1'b1; disp_valid = 1'b0; mem_ack = 1'b0;
      tick();                                   // accept edge
      start = 1'b0;
      idx_regs = 32'($urandom);                 // must not affect ea
      mode = 2'($urandom);                      // mode was captured at accept
      chk("fetch_busy", busy, 1);
      chk("fetch_ready", disp_ready, 1);
      chk("fetch_done", done, 0);

      for (int i = 0; i < fw; i++) begin
         disp_data = 8'($urandom); mem_ack = 1'($urandom);
         tick();
         chk("fetch_wait_ready", disp_ready, 1);
         chk("fetch_wait_req", mem_req, 0);
      end
      disp_valid = 1'b1; disp_data = disp; mem_ack = 1'($urandom);
      tick();                                   // now in CALC
      chk("calc_ready", disp_ready, 0);
      chk("calc_req", mem_req, 0);
      chk("calc_done", done, 0);
      chk("calc_busy", busy, 1);
      disp_valid = 1'($urandom); disp_data = 8'($urandom); mem_ack = 1'($urandom);
      tick();
      disp_valid = 1'b0; mem_ack = 1'b0;
      chk("ea", mem_addr, exp_ea);

      if (md[0]) mem_phase(1'b0, exp_ea, aw);
      if (md[1]) mem_phase(1'b1, exp_ea, aw);

      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_req", mem_req, 0);
      chk("done_addr", mem_addr, exp_ea);
      start = 1'b1; idx_sel = 1'($urandom); mem_ack = 1'($urandom);  // ignored in DONE
      tick();
      start = 1'b0; mem_ack = 1'b0;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_ready", disp_ready, 0);
      chk("post_addr_hold", mem_addr, exp_ea);
      chk("post_err", err, 0);
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b1; start = 1'b0; mode = 2'b00; idx_sel = 1'b0; idx_regs = '0;
      disp_valid = 1'b0; disp_data = '0; mem_ack = 1'b0;
      start3 = 1'b0; sel3 = 2'd0; regs3 = '0;

      repeat (2) tick();
      chk("rst_ready", disp_ready, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst3_busy", busy3, 0);
      reset = 1'b0;
      tick();

      // Address-only, positive max displacement; done in the third cycle
      // after the accept edge, no memory request.
      run_txn(1'b0, 16'h1000, 16'h0000, 8'h7F, 2'b00, 0, 0);
      chk("ex038_addr", mem_addr, 16'h107F);

      // Read, negative displacement, ack after three wait cycles.
      run_txn(1'b1, 16'h0000, 16'h0005, 8'h80, 2'b01, 0, 3);
      chk("ex039_addr", mem_addr, 16'hFF85);

      // Write with address wrap.
      run_txn(1'b0, 16'hFFF0, 16'h0000, 8'h20, 2'b10, 1, 0);
      chk("ex040_addr", mem_addr, 16'h0010);

      // Read-modify-write, zero displacement.
      run_txn(1'b0, 16'h2000, 16'h0000, 8'h00, 2'b11, 2, 1);
      chk("ex041_addr", mem_addr, 16'h2000);

      // Displacement -1 and ack in the first request cycle.
      run_txn(1'b1, 16'h0000, 16'h0000, 8'hFF, 2'b11, 0, 0);

      for (int n = 0; n < 40; n++) begin
         run_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 8'($urandom),
                 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)));
      end

      // Reset in READ with a simultaneous ack and start: aborts, no done.
      idx_regs = {16'h0000, 16'h3000}; idx_sel = 1'b0; mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0; disp_valid = 1'b1; disp_data = 8'h10;
      tick();
      disp_valid = 1'b0;
      tick();
      chk("rr_req", mem_req, 1);
      chk("rr_addr", mem_addr, 16'h3010);
      reset = 1'b1; mem_ack = 1'b1; start = 1'b1;
      tick();
      chk("rr_busy", busy, 0);
      chk("rr_req0", mem_req, 0);
      chk("rr_addr0", mem_addr, 0);
      chk("rr_done", done, 0);
      reset = 1'b0; mem_ack = 1'b0; start = 1'b0;
      tick();
      chk("rr_done_after", done, 0);
      chk("rr_busy_after", busy, 0);

      // Out-of-range select on the three-register instance.
      sel3 = 2'd3; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("err_pulse", err3, 1);
      chk("err_busy", busy3, 0);
      tick();
      chk("err_clear", err3, 0);
      chk("err_idle", busy3, 0);

      // Highest valid select on the same instance.
      regs3 = {16'h4000, 16'h0001, 16'h0002}; sel3 = 2'd2; mode = 2'b00;
      start3 = 1'b1; disp_valid = 1'b1; disp_data = 8'h05;
      tick();
      start3 = 1'b0;
      chk("sel2_busy", busy3, 1);
      chk("sel2_err", err3, 0);
      tick();
      tick();
      chk("sel2_done", done3, 1);
      chk("sel2_addr", mem_addr3, 16'h4005);
      chk("sel2_req", mem_req3, 0);
      disp_valid = 1'b0;
      tick();
      chk("sel2_idle", busy3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
